// File: rtl/delay_ctrl_slave_if.sv
// Avalon-MM register bus between the HPS bridge and the blink-delay slave.
// Only the slave drives readdata/readdatavalid; there is no waitrequest.
interface delay_ctrl_slave_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/delay_ctrl_slave.sv
// Blink-delay register driven by slower/faster key pulses, with an event FIFO
// the HPS can drain over Avalon-MM, plus a level interrupt while events are pending.
module delay_ctrl_slave #(
    parameter int DELAY_WIDTH = 4,
    parameter int DELAY_RESET = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   slower,
    input  logic                   faster,
    delay_ctrl_slave_if.slave      avs,
    output logic [DELAY_WIDTH-1:0] delay,
    output logic                   irq
);
    localparam int DW = DELAY_WIDTH;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = DW + 2;
    localparam logic [DW-1:0] DELAY_MAX = {DW{1'b1}};

    logic [DW-1:0] delay_reg, delay_next;
    logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          irq_en_reg, keys_en_reg;
    logic          irq_reg;
    logic [31:0]   readdata_reg;
    logic          readdatavalid_reg;

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [EW-1:0] head;

    logic          read_req, write_req, delay_wr, ctrl_wr;
    logic          fifo_empty, fifo_full;
    logic          pop, push, key_evt, evt_sat;
    logic [DW-1:0] evt_delay;
    logic [31:0]   rd_data;
    logic          unused_bits;

    // A read in the same cycle as a write wins; the write is dropped.
    assign read_req  = avs.avs_read;
    assign write_req = avs.avs_write & ~avs.avs_read;
    assign delay_wr  = write_req && (avs.avs_address == 2'd0);
    assign ctrl_wr   = write_req && (avs.avs_address == 2'd3);

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr_reg];

    assign pop = read_req && (avs.avs_address == 2'd2) && !fifo_empty;

    // Simultaneous pulses cancel; a DELAY write in the same cycle discards the event.
    assign key_evt   = keys_en_reg && (slower ^ faster) && !delay_wr;
    assign evt_sat   = slower ? (delay_reg == DELAY_MAX) : (delay_reg == '0);
    assign evt_delay = evt_sat ? delay_reg :
                       (slower ? delay_reg + 1'b1 : delay_reg - 1'b1);

    // A full FIFO still accepts a push when a pop frees the head this cycle.
    assign push = key_evt && (!fifo_full || pop);

    always_comb begin
        delay_next = delay_reg;
        if (delay_wr)
            delay_next = avs.avs_writedata[DW-1:0];
        else if (key_evt)
            delay_next = evt_delay;
    end

    always_comb begin
        count_next    = count_reg + CW'(push) - CW'(pop);
        overflow_next = overflow_reg;
        if (ctrl_wr && avs.avs_writedata[2])
            overflow_next = 1'b0;
        if (key_evt && fifo_full && !pop)
            overflow_next = 1'b1;
    end

    always_comb begin
        rd_data = '0;
        case (avs.avs_address)
            2'd0: rd_data[DW-1:0] = delay_reg;
            2'd1: begin
                rd_data[0]      = fifo_empty;
                rd_data[1]      = fifo_full;
                rd_data[2]      = overflow_reg;
                rd_data[4 +: CW] = count_reg;
            end
            2'd2: begin
                if (!fifo_empty) begin
                    rd_data[0]      = 1'b1;
                    rd_data[1]      = head[EW-1];
                    rd_data[2]      = head[EW-2];
                    rd_data[8 +: DW] = head[DW-1:0];
                end
            end
            default: begin
                rd_data[0] = irq_en_reg;
                rd_data[1] = keys_en_reg;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {slower, evt_sat, evt_delay};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delay_reg         <= DW'(DELAY_RESET);
            rd_ptr_reg        <= '0;
            wr_ptr_reg        <= '0;
            count_reg         <= '0;
            overflow_reg      <= 1'b0;
            irq_en_reg        <= 1'b0;
            keys_en_reg       <= 1'b1;
            irq_reg           <= 1'b0;
            readdata_reg      <= '0;
            readdatavalid_reg <= 1'b0;
        end else begin
            delay_reg         <= delay_next;
            count_reg         <= count_next;
            overflow_reg      <= overflow_next;
            readdatavalid_reg <= read_req;
            irq_reg           <= irq_en_reg & (count_reg != '0);
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (read_req)
                readdata_reg <= rd_data;
            if (ctrl_wr) begin
                irq_en_reg  <= avs.avs_writedata[0];
                keys_en_reg <= avs.avs_writedata[1];
            end
        end
    end

    assign unused_bits = ^avs.avs_writedata;

    assign delay                 = delay_reg;
    assign irq                   = irq_reg;
    assign avs.avs_readdata      = readdata_reg;
    assign avs.avs_readdatavalid = readdatavalid_reg;
endmodule
